// File: rtl/roic_lvds_emulator.sv
// ROIC LVDS source emulator: serialises idle, training or pixel-row words MSB first,
// with a frame clock that is high for the first half of every word.
module roic_lvds_emulator #(
    parameter int                    DATA_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] PATTERN_1  = 24'hFFF000,
    parameter logic [DATA_WIDTH-1:0] PATTERN_2  = 24'hFF0000,
    parameter int                    NUM_PIXELS = 256
) (
    input  logic                  ser_clk,
    input  logic                  ser_reset_n,
    input  logic                  enable,
    input  logic                  train_req,
    input  logic                  pattern_sel,
    input  logic                  test_pattern_en,
    input  logic                  sync,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ser_data_out,
    output logic                  ser_fclk_out,
    output logic [11:0]           row_count,
    output logic                  busy,
    output logic                  underrun
);

    localparam int             CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  HALF_BIT = CW'(DATA_WIDTH / 2);
    localparam logic [11:0]    LAST_COL = 12'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, TRAIN, ROW} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         bit_nxt;
    logic [11:0]           col_cnt;
    logic [11:0]           load_col;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  fclk_q;
    logic                  sync_pend;
    logic                  bnd;
    logic                  row_last;
    logic                  row_load;

    assign bnd          = enable && (bit_cnt == LAST_BIT);
    assign bit_nxt      = bnd ? '0 : bit_cnt + 1'b1;
    assign row_last     = (col_cnt == LAST_COL);
    assign ser_data_out = shift_reg[DATA_WIDTH-1];
    assign ser_fclk_out = fclk_q;

    always_ff @(posedge ser_clk or negedge ser_reset_n) begin
        if (!ser_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions only at word boundaries; dropping enable forces IDLE at once.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (bnd) begin
            case (state)
                IDLE: begin
                    if (train_req) begin
                        state_nxt = TRAIN;
                    end else if (sync_pend || sync) begin
                        state_nxt = ROW;
                    end
                end
                TRAIN: begin
                    if (!train_req) begin
                        state_nxt = IDLE;
                    end
                end
                ROW: begin
                    if (row_last) begin
                        state_nxt = train_req ? TRAIN : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The word loaded at a boundary belongs to the state being entered.
    always_comb begin
        busy       = (state == ROW);
        row_load   = bnd && (state_nxt == ROW);
        load_col   = (state == ROW) ? col_cnt + 12'd1 : 12'd0;
        word_ready = row_load && !test_pattern_en && word_valid;
        load_word  = '0;
        case (state_nxt)
            TRAIN: load_word = pattern_sel ? PATTERN_2 : PATTERN_1;
            ROW: begin
                if (test_pattern_en) begin
                    load_word = DATA_WIDTH'({row_count, load_col});
                end else if (word_valid) begin
                    load_word = word_in;
                end
            end
            default: load_word = '0;
        endcase
    end

    always_ff @(posedge ser_clk or negedge ser_reset_n) begin
        if (!ser_reset_n) begin
            bit_cnt   <= '0;
            col_cnt   <= '0;
            shift_reg <= '0;
            fclk_q    <= 1'b0;
            sync_pend <= 1'b0;
            row_count <= '0;
            underrun  <= 1'b0;
        end else if (!enable) begin
            bit_cnt   <= '0;
            col_cnt   <= '0;
            shift_reg <= '0;
            fclk_q    <= 1'b0;
            sync_pend <= 1'b0;
        end else begin
            bit_cnt <= bit_nxt;
            fclk_q  <= (bit_nxt < HALF_BIT);
            if (bnd) begin
                shift_reg <= load_word;
                sync_pend <= 1'b0;
                if (state_nxt == ROW) begin
                    col_cnt <= load_col;
                end else begin
                    col_cnt <= '0;
                end
                if (state == ROW && row_last) begin
                    row_count <= row_count + 12'd1;
                end
                if (row_load && !test_pattern_en && !word_valid) begin
                    underrun <= 1'b1;
                end else if (state == IDLE && state_nxt == ROW) begin
                    underrun <= 1'b0;
                end
            end else begin
                shift_reg <= shift_reg << 1;
                if (sync && state == IDLE) begin
                    sync_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_roic_lvds_emulator.sv
// Bench for roic_lvds_emulator: drives word periods and compares the deserialised
// stream against a word-level reference model.
module tb_roic_lvds_emulator;

    localparam int          NPIX = 4;
    localparam logic [23:0] P1   = 24'hFFF000;
    localparam logic [23:0] P2   = 24'hFF0000;
    localparam int          M_IDLE  = 0;
    localparam int          M_TRAIN = 1;
    localparam int          M_ROW   = 2;

    logic        ser_clk;
    logic        rst_n;
    logic        enable;
    logic        train_req;
    logic        pattern_sel;
    logic        test_pattern_en;
    logic        sync;
    logic [23:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        ser_data_out;
    logic        ser_fclk_out;
    logic [11:0] row_count;
    logic        busy;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    int   m_mode;
    int   m_col;
    int   m_rows;
    logic m_under;
    logic m_pend;

    roic_lvds_emulator #(
        .DATA_WIDTH(24),
        .PATTERN_1 (P1),
        .PATTERN_2 (P2),
        .NUM_PIXELS(NPIX)
    ) dut (
        .ser_clk        (ser_clk),
        .ser_reset_n    (rst_n),
        .enable         (enable),
        .train_req      (train_req),
        .pattern_sel    (pattern_sel),
        .test_pattern_en(test_pattern_en),
        .sync           (sync),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .ser_data_out   (ser_data_out),
        .ser_fclk_out   (ser_fclk_out),
        .row_count      (row_count),
        .busy           (busy),
        .underrun       (underrun)
    );

    initial begin
        ser_clk = 1'b0;
        forever #5 ser_clk = ~ser_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_col   = 0;
        m_rows  = 0;
        m_under = 1'b0;
        m_pend  = 1'b0;
    endtask

    // Word-level behaviour at one boundary, then any sync arriving later in the word.
    task automatic model_bnd(input logic treq, input logic psel, input logic tpe,
                             input logic vld, input logic [23:0] din,
                             input logic sy_now, input logic sy_mid,
                             output logic [23:0] ew, output int erdy, output int ebusy);
        ew   = 24'h0;
        erdy = 0;
        if (m_mode == M_ROW && m_col == NPIX) begin
            m_rows = (m_rows + 1) % 4096;
            m_mode = treq ? M_TRAIN : M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (treq) begin
                m_mode = M_TRAIN;
            end else if (m_pend || sy_now) begin
                m_mode  = M_ROW;
                m_col   = 0;
                m_under = 1'b0;
            end
        end else if (m_mode == M_TRAIN && !treq) begin
            m_mode = M_IDLE;
        end
        m_pend = 1'b0;
        if (m_mode == M_TRAIN) begin
            ew = psel ? P2 : P1;
        end else if (m_mode == M_ROW) begin
            if (tpe) begin
                ew = {12'(m_rows), 12'(m_col)};
            end else if (vld) begin
                ew   = din;
                erdy = 1;
            end else begin
                m_under = 1'b1;
            end
            m_col = m_col + 1;
        end
        ebusy = (m_mode == M_ROW) ? 24 : 0;
        if (sy_mid && m_mode == M_IDLE) m_pend = 1'b1;
    endtask

    // Called at the negedge of a boundary cycle; returns there one word later.
    task automatic run_word(input logic treq, input logic psel, input logic tpe,
                            input logic vld, input logic [23:0] din,
                            input logic sy_now, input logic sy_mid,
                            output logic [23:0] got, output int rdy,
                            output int busy_n, output int fc_bad);
        train_req       = treq;
        pattern_sel     = psel;
        test_pattern_en = tpe;
        word_valid      = vld;
        word_in         = din;
        sync            = sy_now;
        busy_n          = 0;
        fc_bad          = 0;
        got             = 24'h0;
        #1;
        rdy = (word_ready === 1'b1) ? 1 : 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge ser_clk);
            #1;
            sync = sy_mid && (k == 5);
            @(negedge ser_clk);
            got[23-k] = ser_data_out;
            if (ser_fclk_out !== (k < 12)) fc_bad++;
            if (busy === 1'b1) busy_n++;
            if (k < 23 && word_ready === 1'b1) rdy++;
        end
    endtask

    // Right after reset release / re-enable at a negedge: walk the first partial word.
    task automatic start_stream(output int fc_bad, output int d_bad);
        fc_bad = 0;
        d_bad  = 0;
        for (int n = 1; n < 24; n++) begin
            @(posedge ser_clk);
            @(negedge ser_clk);
            if (ser_fclk_out !== (n < 12)) fc_bad++;
            if (ser_data_out !== 1'b0) d_bad++;
        end
    endtask

    task automatic apply_reset();
        int fb;
        int db;
        rst_n = 1'b0; enable = 1'b0; train_req = 1'b0; pattern_sel = 1'b0;
        test_pattern_en = 1'b0; sync = 1'b0; word_in = 24'h0; word_valid = 1'b0;
        repeat (2) @(posedge ser_clk);
        @(negedge ser_clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        model_reset();
        start_stream(fb, db);
    endtask

    task automatic test_reset();
        int fb;
        int db;
        rst_n = 1'b0; enable = 1'b1; train_req = 1'b1; pattern_sel = 1'b0;
        test_pattern_en = 1'b0; sync = 1'b0; word_in = 24'hFFFFFF; word_valid = 1'b1;
        repeat (3) @(posedge ser_clk);
        @(negedge ser_clk);
        tests++; if (ser_data_out !== 1'b0) begin fails++; $display("FAIL reset_data: got %b expected 0", ser_data_out); end
        tests++; if (ser_fclk_out !== 1'b0) begin fails++; $display("FAIL reset_fclk: got %b expected 0", ser_fclk_out); end
        tests++; if (word_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", word_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        tests++; if (row_count !== 12'd0) begin fails++; $display("FAIL reset_row_count: got %0d expected 0", row_count); end
        train_req = 1'b0; word_valid = 1'b0; word_in = 24'h0;
        rst_n = 1'b1;
        model_reset();
        start_stream(fb, db);
        tests++; if (fb != 0) begin fails++; $display("FAIL first_word_fclk: got %0d bad cycles expected 0", fb); end
        tests++; if (db != 0) begin fails++; $display("FAIL first_word_data: got %0d nonzero bits expected 0", db); end
    endtask

    task automatic test_train();
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        logic treq, psel;
        for (int i = 0; i < 9; i++) begin
            treq = (i < 7);
            psel = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            model_bnd(treq, psel, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, ew, erdy, ebusy);
            run_word(treq, psel, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, got, rdy, bsy, fcb);
            tests++; if (got !== ew) begin fails++; $display("FAIL train_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (fcb != 0) begin fails++; $display("FAIL train_fclk[%0d]: got %0d bad cycles expected 0", i, fcb); end
            tests++; if (bsy != 0) begin fails++; $display("FAIL train_busy[%0d]: got %0d expected 0", i, bsy); end
        end
    endtask

    task automatic test_row();
        logic [23:0] words [5] = '{24'hA5A5A5, 24'h000001, 24'h800000, 24'hFFFFFF, 24'h5A5A5A};
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        int tot_rdy = 0;
        int tot_busy = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            model_bnd(1'b0, 1'b0, 1'b0, 1'b1, words[i], i == 0, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, 1'b1, words[i], i == 0, 1'b0, got, rdy, bsy, fcb);
            tot_rdy  += rdy;
            tot_busy += bsy;
            tests++; if (got !== ew) begin fails++; $display("FAIL row_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (rdy != erdy) begin fails++; $display("FAIL row_ready[%0d]: got %0d expected %0d", i, rdy, erdy); end
            tests++; if (fcb != 0) begin fails++; $display("FAIL row_fclk[%0d]: got %0d bad cycles expected 0", i, fcb); end
        end
        tests++; if (tot_rdy != 4) begin fails++; $display("FAIL row_ready_total: got %0d expected 4", tot_rdy); end
        tests++; if (tot_busy != 96) begin fails++; $display("FAIL row_busy_total: got %0d expected 96", tot_busy); end
        tests++; if (row_count !== 12'd1) begin fails++; $display("FAIL row_count_after_row: got %0d expected 1", row_count); end
    endtask

    task automatic test_test_pattern();
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        logic vld, sy;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            vld = 1'($urandom_range(0, 1));
            sy  = (i == 0) || (i == 4) || (i == 5);
            model_bnd(1'b0, 1'b0, 1'b1, vld, 24'($urandom), sy, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b1, vld, 24'($urandom), sy, 1'b0, got, rdy, bsy, fcb);
            tests++; if (got !== ew) begin fails++; $display("FAIL tp_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (rdy != 0) begin fails++; $display("FAIL tp_ready[%0d]: got %0d expected 0", i, rdy); end
            tests++; if (bsy != ebusy) begin fails++; $display("FAIL tp_busy[%0d]: got %0d expected %0d", i, bsy, ebusy); end
            tests++; if (row_count !== 12'(m_rows)) begin fails++; $display("FAIL tp_row_count[%0d]: got %0d expected %0d", i, row_count, m_rows); end
        end
    endtask

    task automatic test_underrun();
        logic [23:0] got;
        logic [23:0] ew;
        logic [23:0] din;
        int rdy, bsy, fcb, erdy, ebusy;
        int row0_rdy = 0;
        logic vld, sy;
        for (int i = 0; i < 11; i++) begin
            vld = (i != 1);
            sy  = (i == 0) || (i == 6);
            din = 24'($urandom);
            model_bnd(1'b0, 1'b0, 1'b0, vld, din, sy, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, vld, din, sy, 1'b0, got, rdy, bsy, fcb);
            if (i < 5) row0_rdy += rdy;
            tests++; if (got !== ew) begin fails++; $display("FAIL ur_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (rdy != erdy) begin fails++; $display("FAIL ur_ready[%0d]: got %0d expected %0d", i, rdy, erdy); end
            tests++; if (underrun !== m_under) begin fails++; $display("FAIL ur_flag[%0d]: got %b expected %b", i, underrun, m_under); end
            if (i == 5) begin
                tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
            end
            if (i == 6) begin
                tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clear_on_row: got %b expected 0", underrun); end
            end
        end
        tests++; if (row0_rdy != 3) begin fails++; $display("FAIL ur_ready_total: got %0d expected 3", row0_rdy); end
    endtask

    task automatic test_train_vs_sync();
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        int tot_busy = 0;
        logic treq;
        for (int i = 0; i < 7; i++) begin
            treq = (i == 1) || (i == 2);
            model_bnd(treq, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b0, i == 0, ew, erdy, ebusy);
            run_word(treq, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b0, i == 0, got, rdy, bsy, fcb);
            tot_busy += bsy;
            tests++; if (got !== ew) begin fails++; $display("FAIL tvs_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (rdy != erdy) begin fails++; $display("FAIL tvs_ready[%0d]: got %0d expected %0d", i, rdy, erdy); end
        end
        tests++; if (tot_busy != 0) begin fails++; $display("FAIL tvs_no_row: got busy %0d cycles expected 0", tot_busy); end
    endtask

    task automatic test_random();
        logic [23:0] got;
        logic [23:0] ew;
        logic [23:0] din;
        int rdy, bsy, fcb, erdy, ebusy;
        logic treq, psel, tpe, vld, syn, sym;
        for (int i = 0; i < 80; i++) begin
            treq = ($urandom_range(0, 7) == 0);
            psel = 1'($urandom_range(0, 1));
            tpe  = ($urandom_range(0, 3) == 0);
            vld  = ($urandom_range(0, 4) != 0);
            syn  = ($urandom_range(0, 2) == 0);
            sym  = ($urandom_range(0, 3) == 0);
            din  = 24'($urandom);
            model_bnd(treq, psel, tpe, vld, din, syn, sym, ew, erdy, ebusy);
            run_word(treq, psel, tpe, vld, din, syn, sym, got, rdy, bsy, fcb);
            tests++; if (got !== ew) begin fails++; $display("FAIL rnd_word[%0d]: got %h expected %h", i, got, ew); end
            tests++; if (rdy != erdy) begin fails++; $display("FAIL rnd_ready[%0d]: got %0d expected %0d", i, rdy, erdy); end
            tests++; if (bsy != ebusy) begin fails++; $display("FAIL rnd_busy[%0d]: got %0d expected %0d", i, bsy, ebusy); end
            tests++; if (fcb != 0) begin fails++; $display("FAIL rnd_fclk[%0d]: got %0d bad cycles expected 0", i, fcb); end
            tests++; if (row_count !== 12'(m_rows)) begin fails++; $display("FAIL rnd_row_count[%0d]: got %0d expected %0d", i, row_count, m_rows); end
            tests++; if (underrun !== m_under) begin fails++; $display("FAIL rnd_underrun[%0d]: got %b expected %b", i, underrun, m_under); end
        end
        train_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_bnd(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0, got, rdy, bsy, fcb);
        end
    endtask

    task automatic test_enable_abort();
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        int fb, db;
        int rows_before;
        for (int i = 0; i < 2; i++) begin
            model_bnd(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, i == 0, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, i == 0, 1'b0, got, rdy, bsy, fcb);
        end
        rows_before = m_rows;
        repeat (6) @(posedge ser_clk);
        @(negedge ser_clk);
        enable = 1'b0;
        @(posedge ser_clk);
        #1;
        tests++; if (ser_data_out !== 1'b0) begin fails++; $display("FAIL abort_data: got %b expected 0", ser_data_out); end
        tests++; if (ser_fclk_out !== 1'b0) begin fails++; $display("FAIL abort_fclk: got %b expected 0", ser_fclk_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (30) @(posedge ser_clk);
        #1;
        tests++; if (ser_fclk_out !== 1'b0) begin fails++; $display("FAIL disabled_fclk: got %b expected 0", ser_fclk_out); end
        @(negedge ser_clk);
        enable = 1'b1;
        m_mode = M_IDLE;
        m_pend = 1'b0;
        start_stream(fb, db);
        tests++; if (fb != 0 || db != 0) begin fails++; $display("FAIL reenable_stream: got %0d/%0d bad fclk/data cycles expected 0/0", fb, db); end
        for (int i = 0; i < 2; i++) begin
            model_bnd(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0, got, rdy, bsy, fcb);
            tests++; if (bsy != 0) begin fails++; $display("FAIL abort_idle_busy[%0d]: got %0d expected 0", i, bsy); end
        end
        tests++; if (row_count !== 12'(rows_before)) begin fails++; $display("FAIL abort_row_count: got %0d expected %0d", row_count, rows_before); end
    endtask

    task automatic test_reset_midrow();
        logic [23:0] got;
        logic [23:0] ew;
        int rdy, bsy, fcb, erdy, ebusy;
        int fb, db;
        for (int i = 0; i < 2; i++) begin
            model_bnd(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, i == 0, 1'b0, ew, erdy, ebusy);
            run_word(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, i == 0, 1'b0, got, rdy, bsy, fcb);
        end
        repeat (11) @(posedge ser_clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (ser_data_out !== 1'b0 || ser_fclk_out !== 1'b0) begin fails++; $display("FAIL midreset_serial: got data %b fclk %b expected 0 0", ser_data_out, ser_fclk_out); end
        tests++; if (busy !== 1'b0 || word_ready !== 1'b0 || underrun !== 1'b0) begin fails++; $display("FAIL midreset_flags: got busy %b ready %b underrun %b expected 0 0 0", busy, word_ready, underrun); end
        tests++; if (row_count !== 12'd0) begin fails++; $display("FAIL midreset_row_count: got %0d expected 0", row_count); end
        @(negedge ser_clk);
        word_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        start_stream(fb, db);
        tests++; if (fb != 0 || db != 0) begin fails++; $display("FAIL midreset_restart: got %0d/%0d bad fclk/data cycles expected 0/0", fb, db); end
        tests++; if (row_count !== 12'd0) begin fails++; $display("FAIL midreset_row_count_after: got %0d expected 0", row_count); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_row();
        test_test_pattern();
        test_underrun();
        test_train_vs_sync();
        test_random();
        test_enable_abort();
        test_reset_midrow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
